led_pattern_gen: RTL and testbench

Parametrised LED pattern engine for the DE0-Nano basics designs, generalising the fixed single-pattern LED demo. It debounces an arbitrary number of active-low push-buttons and drives an LED bank of configurable width with one of four switch-selected patterns (binary count, rotate, bounce, blink) at a switch-selected step rate. It sits directly between the board pins (KEY, SW) and the LED outputs of a top-level board wrapper.

---
 rtl/led_pattern_gen_if.sv | 24 ++
 rtl/led_pattern_gen.sv | 152 +++++++++++++++
 tb/tb_led_pattern_gen.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_gen_if.sv
// Pin-level bundle between the board wrapper and the LED pattern engine.
// No handshake: LED is a level output, KEY_EVENT is a one-cycle pulse, KEY/SW are raw asynchronous pins.
interface led_pattern_gen_if #(
  parameter int LED_W    = 8,
  parameter int NUM_KEYS = 2
);
  logic [NUM_KEYS-1:0] KEY;
  logic [3:0]          SW;
  logic [LED_W-1:0]    LED;
  logic [NUM_KEYS-1:0] KEY_EVENT;
  logic                dbg_run;
  logic                dbg_dir;
  logic [1:0]          dbg_mode;

  modport master (
    output KEY, SW,
    input  LED, KEY_EVENT, dbg_run, dbg_dir, dbg_mode
  );

  modport slave (
    input  KEY, SW,
    output LED, KEY_EVENT, dbg_run, dbg_dir, dbg_mode
  );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern engine: synchronises and debounces keys, then steps one of four
// switch-selected patterns (count, rotate, bounce, blink) at a switch-scaled rate.
module led_pattern_gen #(
  parameter int LED_W           = 8,
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int STEP_CYCLES     = 5000000
) (
  input logic              CLOCK_50,
  input logic              RESET_N,
  led_pattern_gen_if.slave pins
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  // Wide enough for the slowest period (speed shift of 3) minus one.
  localparam int TW = $clog2(STEP_CYCLES * 8);
  localparam logic [TW-1:0] STEP_W = TW'(STEP_CYCLES);

  typedef enum logic [1:0] {
    MODE_COUNT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  logic [NUM_KEYS-1:0]         key_s1_q, key_s2_q;
  logic [3:0]                  sw_s1_q, sw_s2_q;
  logic [NUM_KEYS-1:0]         stable_q, stable_d, stable_prev_q, key_event_q;
  logic [NUM_KEYS-1:0][DW-1:0] db_cnt_q, db_cnt_d;
  mode_e                       mode_q, mode_d, sw_mode;
  logic [TW-1:0]               tick_q, tick_d, period_m1;
  logic [LED_W-1:0]            led_q, led_d;
  logic                        run_q, run_d, dir_q, dir_d;
  logic                        step, dir_tgl;

  generate
    if (NUM_KEYS > 1) begin : g_dir_key
      assign dir_tgl = key_event_q[1];
    end else begin : g_no_dir_key
      assign dir_tgl = 1'b0;
    end
  endgenerate

  assign sw_mode   = mode_e'(sw_s2_q[1:0]);
  assign period_m1 = (STEP_W << sw_s2_q[3:2]) - TW'(1);

  // A differing sample run of DEBOUNCE_CYCLES accepts the new level; any agreeing sample restarts it.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = key_s2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    tick_d = tick_q;
    led_d  = led_q;
    dir_d  = dir_q;
    run_d  = run_q ^ key_event_q[0];
    step   = 1'b0;

    if (sw_mode != mode_q) begin
      mode_d = sw_mode;
      tick_d = '0;
      unique case (sw_mode)
        MODE_ROTATE: led_d = LED_W'(1);
        MODE_BOUNCE: begin
          led_d = LED_W'(1);
          dir_d = 1'b0;
        end
        default:     led_d = '0;
      endcase
    end else if (run_q) begin
      if (tick_q >= period_m1) begin
        tick_d = '0;
        step   = 1'b1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    if (step) begin
      unique case (mode_q)
        MODE_COUNT:  led_d = dir_q ? led_q - LED_W'(1) : led_q + LED_W'(1);
        MODE_ROTATE: led_d = dir_q ? {led_q[0], led_q[LED_W-1:1]}
                                   : {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_BOUNCE: begin
          if (!dir_q && led_q[LED_W-1]) begin
            dir_d = 1'b1;
            led_d = led_q >> 1;
          end else if (dir_q && led_q[0]) begin
            dir_d = 1'b0;
            led_d = led_q << 1;
          end else begin
            led_d = dir_q ? led_q >> 1 : led_q << 1;
          end
        end
        default:     led_d = ~led_q;
      endcase
    end

    // The key toggle lands after any end-reverse so a press at the wall is not lost.
    dir_d = dir_d ^ dir_tgl;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      key_s1_q      <= '1;
      key_s2_q      <= '1;
      sw_s1_q       <= '0;
      sw_s2_q       <= '0;
      stable_q      <= '1;
      stable_prev_q <= '1;
      key_event_q   <= '0;
      db_cnt_q      <= '0;
      mode_q        <= MODE_COUNT;
      tick_q        <= '0;
      led_q         <= '0;
      run_q         <= 1'b1;
      dir_q         <= 1'b0;
    end else begin
      key_s1_q      <= pins.KEY;
      key_s2_q      <= key_s1_q;
      sw_s1_q       <= pins.SW;
      sw_s2_q       <= sw_s1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      key_event_q   <= stable_prev_q & ~stable_q;
      db_cnt_q      <= db_cnt_d;
      mode_q        <= mode_d;
      tick_q        <= tick_d;
      led_q         <= led_d;
      run_q         <= run_d;
      dir_q         <= dir_d;
    end
  end

  assign pins.LED       = led_q;
  assign pins.KEY_EVENT = key_event_q;
  assign pins.dbg_run   = run_q;
  assign pins.dbg_dir   = dir_q;
  assign pins.dbg_mode  = mode_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed and random key/switch stimulus, a
// behavioural pattern model, and a monitor that scores every LED change and key event.
module tb_led_pattern_gen;

  localparam int LED_W    = 8;
  localparam int NUM_KEYS = 2;
  localparam int DB       = 4;
  localparam int STEP     = 3;
  localparam int MODV     = 1 << LED_W;
  localparam int TOPV     = 1 << (LED_W - 1);

  typedef struct packed {
    int unsigned      cyc;
    logic [LED_W-1:0] val;
  } led_exp_t;

  typedef struct packed {
    int unsigned         cyc;
    logic [NUM_KEYS-1:0] mask;
  } ev_exp_t;

  logic clk;
  logic rst_n;

  led_pattern_gen_if #(.LED_W(LED_W), .NUM_KEYS(NUM_KEYS)) pins ();

  led_pattern_gen #(
    .LED_W(LED_W), .NUM_KEYS(NUM_KEYS),
    .DEBOUNCE_CYCLES(DB), .STEP_CYCLES(STEP)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .pins    (pins)
  );

  led_exp_t    exp_led_q[$];
  ev_exp_t     exp_ev_q[$];
  ev_exp_t     tog_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [LED_W-1:0] last_led = '0;

  // Reference state: plain integers, stepped by the pattern rules.
  int       m_led = 0;
  int       m_mode = 0;
  int       m_phase = 0;
  bit       m_run = 1'b1;
  bit       m_dir = 1'b0;
  logic [3:0] sw_h0 = '0;
  logic [3:0] sw_h1 = '0;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endfunction

  // ---------------- reference model ----------------
  task automatic model_edge();
    int       old;
    int       per;
    ev_exp_t  t;
    led_exp_t e;
    old = m_led;
    if (rst_n !== 1'b1) begin
      m_led = 0; m_run = 1'b1; m_dir = 1'b0; m_mode = 0; m_phase = 0;
      sw_h0 = '0; sw_h1 = '0;
      tog_q.delete();
    end else begin
      per = STEP << sw_h1[3:2];
      if (int'(sw_h1[1:0]) != m_mode) begin
        m_mode  = int'(sw_h1[1:0]);
        m_phase = 0;
        m_led   = (m_mode == 1 || m_mode == 2) ? 1 : 0;
        if (m_mode == 2) m_dir = 1'b0;
      end else if (m_run) begin
        m_phase++;
        if (m_phase >= per) begin
          m_phase = 0;
          case (m_mode)
            0: m_led = (m_led + (m_dir ? MODV - 1 : 1)) % MODV;
            1: m_led = m_dir ? (m_led / 2 + (m_led % 2) * TOPV)
                             : ((m_led * 2) % MODV + m_led / TOPV);
            2: begin
              if (!m_dir) begin
                if (m_led >= TOPV) begin m_dir = 1'b1; m_led = m_led / 2; end
                else m_led = m_led * 2;
              end else begin
                if (m_led % 2 == 1) begin m_dir = 1'b0; m_led = m_led * 2; end
                else m_led = m_led / 2;
              end
            end
            default: m_led = MODV - 1 - m_led;
          endcase
        end
      end
      // A key press acts on the edge after its KEY_EVENT cycle.
      while (tog_q.size() > 0 && tog_q[0].cyc + 1 <= cyc) begin
        t = tog_q.pop_front();
        if (t.mask[0]) m_run = !m_run;
        if (t.mask[1]) m_dir = !m_dir;
      end
      sw_h1 = sw_h0;
      sw_h0 = pins.SW;
    end
    if (m_led != old) begin
      e.cyc = cyc;
      e.val = LED_W'(m_led);
      exp_led_q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_edge();
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    led_exp_t le;
    ev_exp_t  ee;
    @(negedge clk);
    if (mon_en) begin
      if (exp_led_q.size() > 0 && exp_led_q[0].cyc < cyc) begin
        le = exp_led_q.pop_front();
        n_checks++; n_fail++;
        $display("FAIL led_missing: LED stayed %0h, expected %0h at cycle %0d", pins.LED, le.val, le.cyc);
      end
      if (pins.LED !== last_led) begin
        if (exp_led_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL led_unexpected: LED %0h -> %0h at cycle %0d, expected no change", last_led, pins.LED, cyc);
        end else begin
          le = exp_led_q.pop_front();
          chk("led_value", 32'(pins.LED), 32'(le.val));
          chk("led_cycle", cyc, le.cyc);
        end
        last_led = pins.LED;
      end
      if (exp_ev_q.size() > 0 && exp_ev_q[0].cyc < cyc) begin
        ee = exp_ev_q.pop_front();
        n_checks++; n_fail++;
        $display("FAIL event_missing: no KEY_EVENT %0b, expected at cycle %0d", ee.mask, ee.cyc);
      end
      if (pins.KEY_EVENT !== '0) begin
        if (exp_ev_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL event_unexpected: KEY_EVENT %0b at cycle %0d, expected 0", pins.KEY_EVENT, cyc);
        end else begin
          ee = exp_ev_q.pop_front();
          chk("event_mask", 32'(pins.KEY_EVENT), 32'(ee.mask));
          chk("event_cycle", cyc, ee.cyc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx, input int len);
    ev_exp_t e;
    pins.KEY[idx] = 1'b0;
    if (len >= DB) begin
      e.cyc       = cyc + 2 + DB + 1;
      e.mask      = '0;
      e.mask[idx] = 1'b1;
      exp_ev_q.push_back(e);
      tog_q.push_back(e);
    end
    tick(len);
    pins.KEY[idx] = 1'b1;
    tick(DB + 4);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_led"},   32'(pins.LED), 32'h0);
    chk({tag, "_event"}, 32'(pins.KEY_EVENT), 32'h0);
    chk({tag, "_run"},   32'(pins.dbg_run), 32'h1);
    chk({tag, "_dir"},   32'(pins.dbg_dir), 32'h0);
    chk({tag, "_mode"},  32'(pins.dbg_mode), 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    pins.KEY = '1;
    pins.SW  = 4'b0000;
    tick(3);
    check_reset_state("reset");
    rst_n    = 1'b1;
    last_led = pins.LED;
    mon_en   = 1'b1;

    // Count up, glitch, pause and resume.
    tick(20);
    press(0, 2);
    press(0, 10);
    tick(15);
    press(0, 10);
    tick(10);

    // Rotate with wrap, then reverse.
    pins.SW = 4'b0001;
    tick(30);
    press(1, 6);
    tick(30);

    // Bounce across both walls, then a direction press.
    pins.SW = 4'b0010;
    tick(60);
    press(1, 5);
    tick(20);

    // Blink; leave dir set to down for the count underflow.
    pins.SW = 4'b0011;
    tick(15);
    if (!m_dir) press(1, 5);
    pins.SW = 4'b0000;
    tick(12);
    pins.SW = 4'b1100;
    tick(60);

    // Random mix of switch changes, key presses and glitches.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       begin pins.SW = 4'($urandom_range(0, 15)); tick($urandom_range(5, 40)); end
        1:       press($urandom_range(0, 1), $urandom_range(1, 9));
        default: tick($urandom_range(1, 30));
      endcase
    end

    // Reset while paused, reversed, mid-pattern and mid-debounce.
    pins.SW = 4'b0001;
    tick(12);
    if (m_run) press(0, 5);
    if (!m_dir) press(1, 5);
    pins.KEY[0] = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check_reset_state("midreset");
    rst_n = 1'b1;
    tick(1);
    pins.KEY[0] = 1'b1;
    tick(30);

    tick(10);
    chk("led_queue_drained", exp_led_q.size(), 32'h0);
    chk("event_queue_drained", exp_ev_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
